// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding and default widths for the ramp
// sequencing controller (count_seq_ctrl) and its counter core.
package count_seq_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_HOLD_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        HOLD = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } count_seq_state_t;

endpackage

// File: rtl/count_seq_updown_core.sv
// updown_core: WIDTH-bit synchronous up/down counter.
// clr has priority over enable; up_down=1 increments, 0 decrements.
// The controller keeps q inside 0..limit, so no wrap handling is needed here.
module updown_core
    import count_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] q
);

    // counter register: synchronous reset, then clear, then count
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (enable) begin
            q <= up_down ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: drives an up/down counter through a ramp
// 0 -> limit, dwell for hold+1 cycles, limit -> 0, then a one-cycle done.
// Optional feature macro COUNT_SEQ_ABORT_EN adds abort/aborted: an abort in
// UP or HOLD jumps straight to DOWN, which ramps down from the current q.
// busy/done/dir are registered, so start has no combinational path to them.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  limit,
    input  logic [HOLD_W-1:0] hold,
`ifdef COUNT_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic              dir,
    output logic [WIDTH-1:0]  q
);

    count_seq_state_t  state;
    logic [WIDTH-1:0]  limit_r;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hc;

    logic ctr_clr;
    logic ctr_en;
    logic ctr_up;
    logic abort_hit;

`ifdef COUNT_SEQ_ABORT_EN
    // abort only matters while ramping up or dwelling
    assign abort_hit = abort && ((state == UP) || (state == HOLD));
`else
    assign abort_hit = 1'b0;
`endif

    // counter controls decoded from the current state; an abort edge in UP
    // freezes q so the down ramp starts from the value seen when aborting
    always_comb begin
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        ctr_up  = 1'b0;
        case (state)
            IDLE: ctr_clr = start;
            UP: begin
                ctr_en = (q != limit_r) && !abort_hit;
                ctr_up = 1'b1;
            end
            DOWN:    ctr_en = (q != '0);
            default: ;
        endcase
    end

    updown_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .enable  (ctr_en),
        .up_down (ctr_up),
        .q       (q)
    );

    // sequencing FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            limit_r <= '0;
            hold_r  <= '0;
            hc      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dir     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        limit_r <= limit;
                        hold_r  <= hold;
                        state   <= UP;
                        busy    <= 1'b1;
                        dir     <= 1'b1;
                    end
                end
                UP: begin
                    if (abort_hit) begin
                        state <= DOWN;
                        dir   <= 1'b0;
                    end else if (q == limit_r) begin
                        state <= HOLD;
                        hc    <= hold_r;
                        dir   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (abort_hit || (hc == '0)) begin
                        state <= DOWN;
                    end else begin
                        hc <= hc - 1'b1;
                    end
                end
                DOWN: begin
                    if (q == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    dir   <= 1'b0;
                end
            endcase
        end
    end

`ifdef COUNT_SEQ_ABORT_EN
    // aborted flag: set on an effective abort, cleared on the next accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted <= 1'b0;
        end else if ((state == IDLE) && start) begin
            aborted <= 1'b0;
        end else if (abort_hit) begin
            aborted <= 1'b1;
        end
    end
`endif

endmodule
